sbox_share_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 30 +++
 rtl/sbox_share_sched_lane_bank.sv | 13 +
 rtl/sbox_share_sched.sv | 78 +++++++
 tb/tb_sbox_share_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, scheduler enums and the S-box byte function
package aes_pkg;
  typedef logic [7:0] byte_t;
  typedef logic [31:0] word_t;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE, DATA_RUN, KEY_RUN} sched_state_t;
  typedef enum logic {GNT_DATA, GNT_KEY} grant_t;
  localparam int NBYTES = 16;
  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254 (0 maps to 0), then the AES affine map
  function automatic byte_t sbox(byte_t a);
    byte_t s, r;
    s = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/sbox_share_sched_lane_bank.sv
// sbox_lane_bank: LANES parallel combinational S-boxes
// Ports: bytes_raw - LANES input bytes, bytes_sub - substituted bytes at the same positions
module sbox_lane_bank #(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] bytes_raw,
  output logic [LANES*8-1:0] bytes_sub
);
  import aes_pkg::*;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign bytes_sub[i*8 +: 8] = sbox(bytes_raw[i*8 +: 8]);
  end
endmodule

// File: rtl/sbox_share_sched.sv
// sbox_share_sched: column-serial SubBytes engine shared between a data and a key requester
// Ports: clk, reset (sync, active high); d_valid/d_ready/d_in request and d_out_valid/d_out_ready/d_out
// result for 128-bit states; k_valid/k_ready/k_in and k_out_valid/k_out_ready/k_out for 32-bit words.
// Macro SBS_CONTENTION_CNT_EN adds contention_cnt[15:0], a saturating count of cycles a requester was
// held off by the other one.
module sbox_share_sched #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic [127:0] d_in,
  output logic         d_out_valid,
  input  logic         d_out_ready,
  output logic [127:0] d_out,
  input  logic         k_valid,
  output logic         k_ready,
  input  logic [31:0]  k_in,
  output logic         k_out_valid,
  input  logic         k_out_ready,
  output logic [31:0]  k_out
`ifdef SBS_CONTENTION_CNT_EN
  ,
  output logic [15:0]  contention_cnt
`endif
);
  import aes_pkg::*;
  localparam int NPASS = NBYTES / LANES;
  localparam int W = LANES * 8;
  sched_state_t state, state_nx;
  grant_t last_grant;
  state_t work;
  logic [1:0] pass;
  logic [W-1:0] bank_out;
  logic de, ke, gd, gk, last_pass;
  assign de = d_valid && !d_out_valid;
  assign ke = k_valid && !k_out_valid;
  assign gd = state == IDLE && de && (!ke || last_grant == GNT_KEY);
  assign gk = state == IDLE && ke && !gd;
  assign d_ready = !reset && state == IDLE && !d_out_valid && !gk;
  assign k_ready = !reset && state == IDLE && !k_out_valid && !gd;
  assign last_pass = pass == 2'(NPASS - 1);
  // the working register shifts left one lane group per pass, so the bank always reads its top bytes;
  // a key word is parked in the top 32 bits and the spare lanes just see zeros
  sbox_lane_bank #(.LANES(LANES)) u_bank (
    .bytes_raw(work[127 -: W]),
    .bytes_sub(bank_out)
  );
  always_comb
    state_nx = gd ? DATA_RUN : gk ? KEY_RUN : (state == DATA_RUN && !last_pass) ? DATA_RUN : IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      last_grant <= GNT_KEY;
      work <= '0;
      pass <= '0;
      d_out <= '0;
      d_out_valid <= 1'b0;
      k_out <= '0;
      k_out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      last_grant <= (state == IDLE && de && ke) ? (gd ? GNT_DATA : GNT_KEY) : last_grant;
      work <= gd ? d_in : gk ? {k_in, 96'h0} : state_t'(work << W);
      pass <= (state == DATA_RUN && !last_pass) ? pass + 2'd1 : 2'd0;
      d_out <= state == DATA_RUN ? state_t'(d_out << W) | state_t'(bank_out) : d_out;
      d_out_valid <= (state == DATA_RUN && last_pass) || (d_out_valid && !d_out_ready);
      k_out <= state == KEY_RUN ? bank_out[W-1 -: 32] : k_out;
      k_out_valid <= state == KEY_RUN || (k_out_valid && !k_out_ready);
    end
`ifdef SBS_CONTENTION_CNT_EN
  logic blocked;
  assign blocked = (de && (state == KEY_RUN || gk)) || (ke && (state == DATA_RUN || gd));
  always_ff @(posedge clk)
    contention_cnt <= reset ? 16'd0 : (blocked && contention_cnt != 16'hFFFF) ? contention_cnt + 16'd1 : contention_cnt;
`endif
endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: table vectors, directed corner sequences and a random run checked by a transaction model
module tb_sbox_share_sched;
  import aes_pkg::*;
  localparam int LANES = 4;
  localparam int NPASS = 16 / LANES;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_valid = 1'b0, d_out_ready = 1'b1, k_valid = 1'b0, k_out_ready = 1'b1;
  logic d_ready, d_out_valid, k_ready, k_out_valid;
  logic [127:0] d_in = '0, d_out;
  logic [31:0] k_in = '0, k_out;
  logic [15:0] contention_cnt;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sbox_share_sched #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_ready(d_ready), .d_in(d_in),
    .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .d_out(d_out),
    .k_valid(k_valid), .k_ready(k_ready), .k_in(k_in),
    .k_out_valid(k_out_valid), .k_out_ready(k_out_ready), .k_out(k_out)
`ifdef SBS_CONTENTION_CNT_EN
    , .contention_cnt(contention_cnt)
`endif
  );
  logic [2047:0] tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic byte_t sb(byte_t x);
    return tab[2047 - 8*int'(x) -: 8];
  endfunction
  function automatic state_t sub128(state_t v);
    state_t r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sb(v[127 - 8*i -: 8]);
    return r;
  endfunction
  function automatic word_t sub32(word_t v);
    return {sb(v[31:24]), sb(v[23:16]), sb(v[15:8]), sb(v[7:0])};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // transaction model: bank busy countdown, held results, round-robin memory of the last contested grant
  int busy = 0;
  bit run_key = 0, m_dv = 0, m_kv = 0, m_lg = 1;
  state_t m_dres = '0;
  word_t m_kres = '0;
  int m_cnt = 0;
  always @(negedge clk) begin
    bit idle, de, ke, gd, gk, eb;
    if (reset) begin
      chk("m_rst_d_ready", d_ready, 0);
      chk("m_rst_k_ready", k_ready, 0);
      busy = 0; m_dv = 0; m_kv = 0; m_lg = 1; m_cnt = 0;
    end else begin
      idle = busy == 0;
      de = d_valid && !m_dv;
      ke = k_valid && !m_kv;
      gd = idle && de && (!ke || m_lg);
      gk = idle && ke && !gd;
      chk("m_d_ready", d_ready, idle && !m_dv && !gk);
      chk("m_k_ready", k_ready, idle && !m_kv && !gd);
      chk("m_d_out_valid", d_out_valid, m_dv);
      chk("m_k_out_valid", k_out_valid, m_kv);
      if (m_dv) chk("m_d_out", d_out, m_dres);
      if (m_kv) chk("m_k_out", k_out, m_kres);
`ifdef SBS_CONTENTION_CNT_EN
      chk("m_contention_cnt", contention_cnt, m_cnt);
`endif
      eb = (de && (busy > 0 ? run_key : gk)) || (ke && (busy > 0 ? !run_key : gd));
      if (eb && m_cnt < 65535) m_cnt++;
      if (m_dv && d_out_ready) m_dv = 0;
      if (m_kv && k_out_ready) m_kv = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          if (run_key) m_kv = 1;
          else m_dv = 1;
        end
      end else if (gd) begin
        busy = NPASS; run_key = 0; m_dres = sub128(d_in);
      end else if (gk) begin
        busy = 1; run_key = 1; m_kres = sub32(k_in);
      end
      if (idle && de && ke) m_lg = gk;
    end
  end
  // wait for the grant of one requester at a negedge, then pass the edge and drop its valid
  task automatic await(input bit key);
    int n;
    n = 0;
    @(negedge clk);
    while (!(key ? k_ready : d_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(key ? "k_grant" : "d_grant", key ? k_ready : d_ready, 1);
    @(posedge clk); #1;
    if (key) k_valid = 0;
    else d_valid = 0;
  endtask
  task automatic do_data(input state_t v, input state_t exp, input int hold);
    int lat;
    d_in = v; d_valid = 1; d_out_ready = 0;
    await(0);
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d_latency", lat, NPASS);
    chk("d_out", d_out, exp);
    repeat (hold) begin
      @(negedge clk);
      chk("d_hold_valid", d_out_valid, 1);
      chk("d_hold_out", d_out, exp);
      chk("d_hold_ready", d_ready, 0);
    end
    @(posedge clk); #1;
    d_out_ready = 1;
    @(posedge clk); #1;
    chk("d_out_clear", d_out_valid, 0);
  endtask
  task automatic do_key(input word_t v, input word_t exp, input int hold);
    int lat;
    k_in = v; k_valid = 1; k_out_ready = 0;
    await(1);
    lat = 0;
    while (!k_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("k_latency", lat, 1);
    chk("k_out", k_out, exp);
    repeat (hold) begin
      @(negedge clk);
      chk("k_hold_valid", k_out_valid, 1);
      chk("k_hold_out", k_out, exp);
      chk("k_hold_ready", k_ready, 0);
    end
    @(posedge clk); #1;
    k_out_ready = 1;
    @(posedge clk); #1;
    chk("k_out_clear", k_out_valid, 0);
  endtask
  task automatic pulse_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask
  typedef struct {state_t din; state_t dexp;} dvec_t;
  typedef struct {word_t kin; word_t kexp;} kvec_t;
  dvec_t dvec [4];
  kvec_t kvec [4];
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    dvec[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    dvec[1] = '{{16{8'h53}}, {16{8'hed}}};
    dvec[2] = '{{16{8'h00}}, {16{8'h63}}};
    dvec[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
    kvec[0] = '{32'hcf4f3c09, 32'h8a84eb01};
    kvec[1] = '{32'h00000000, 32'h63636363};
    kvec[2] = '{32'h53535353, 32'hedededed};
    kvec[3] = '{32'h01020304, 32'h7c777bf2};
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_k_ready", k_ready, 0);
    chk("rst_d_out_valid", d_out_valid, 0);
    chk("rst_k_out_valid", k_out_valid, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_k_out", k_out, 0);
`ifdef SBS_CONTENTION_CNT_EN
    chk("rst_contention_cnt", contention_cnt, 0);
`endif
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 4; i++) do_data(dvec[i].din, dvec[i].dexp, i);
    for (int i = 0; i < 4; i++) do_key(kvec[i].kin, kvec[i].kexp, i == 0 ? 3 : 1);
    // simultaneous requests: data first, key on the cycle data frees the bank, then key wins the rematch
    pulse_reset();
    d_in = dvec[0].din; k_in = kvec[0].kin; d_valid = 1; k_valid = 1;
    @(negedge clk);
    chk("tie1_d_ready", d_ready, 1);
    chk("tie1_k_ready", k_ready, 0);
    @(posedge clk); #1;
    d_valid = 0;
    repeat (NPASS) begin
      @(negedge clk);
      chk("tie1_k_wait", k_ready, 0);
    end
    @(negedge clk);
    chk("tie1_k_grant", k_ready, 1);
    @(posedge clk); #1;
    k_valid = 0;
`ifdef SBS_CONTENTION_CNT_EN
    @(negedge clk);
    chk("tie1_contention_cnt", contention_cnt, 5);
`endif
    repeat (4) @(posedge clk);
    #1;
    d_in = dvec[3].din; k_in = kvec[3].kin; d_valid = 1; k_valid = 1;
    @(negedge clk);
    chk("tie2_k_ready", k_ready, 1);
    chk("tie2_d_ready", d_ready, 0);
    @(posedge clk); #1;
    k_valid = 0;
    @(negedge clk);
    chk("tie2_d_wait", d_ready, 0);
    @(negedge clk);
    chk("tie2_d_grant", d_ready, 1);
    @(posedge clk); #1;
    d_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    // key service while a data result is held
    d_in = dvec[1].din; d_valid = 1; d_out_ready = 0;
    await(0);
    repeat (NPASS) @(posedge clk);
    #1;
    chk("xb_d_valid", d_out_valid, 1);
    k_in = 32'h00000000; k_valid = 1; k_out_ready = 0;
    @(negedge clk);
    chk("xb_k_ready", k_ready, 1);
    chk("xb_d_ready", d_ready, 0);
    @(posedge clk); #1;
    k_valid = 0;
    @(posedge clk); #1;
    chk("xb_k_valid", k_out_valid, 1);
    chk("xb_k_out", k_out, 32'h63636363);
    chk("xb_d_held", d_out, dvec[1].dexp);
    chk("xb_d_ready_held", d_ready, 0);
    k_out_ready = 1;
    @(posedge clk); #1;
    chk("xb_k_clear", k_out_valid, 0);
    chk("xb_d_still_valid", d_out_valid, 1);
    d_out_ready = 1;
    @(posedge clk); #1;
    chk("xb_d_clear", d_out_valid, 0);
    // reset in the middle of a data run discards it
    d_in = {16{8'h12}}; d_valid = 1;
    await(0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_d_valid", d_out_valid, 0);
      chk("mid_rst_k_valid", k_out_valid, 0);
    end
    @(posedge clk); #1;
    do_data({16{8'h53}}, {16{8'hed}}, 0);
    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      reset = $urandom_range(0, 299) == 0;
      d_valid = 1'($urandom_range(0, 1));
      k_valid = 1'($urandom_range(0, 1));
      d_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      k_in = $urandom();
      d_out_ready = $urandom_range(0, 3) != 0;
      k_out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    reset = 0; d_valid = 0; k_valid = 0; d_out_ready = 1; k_out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
